// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between an instruction-fetch port and a load/store port.
// Data has priority; a saturating starvation counter forces an inst grant after STARVE_LIMIT denials.
module sram_port_arbiter #(
    parameter int AW           = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_gnt,
    output logic          inst_rvalid,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [31:0]   data_addr,
    input  logic [3:0]    data_sel,
    input  logic [31:0]   data_wdata,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [31:0]   rdata,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_sel,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic          inst_stall,
    output logic          data_stall
);

    typedef enum logic [1:0] {
        RET_NONE,
        RET_INST,
        RET_DATA
    } ret_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    ret_t       state, state_next;
    logic [3:0] starve_cnt, starve_next;
    logic       grant_inst, grant_data;

    // Byte-offset and above-window address bits never reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0],
                                data_addr[31:AW+2], data_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RET_NONE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Grants are gated by rst so every output reads zero while reset is held.
    always_comb begin
        grant_inst = !rst && inst_req && (!data_req || (starve_cnt == LIMIT));
        grant_data = !rst && data_req && !grant_inst;
    end

    always_comb begin
        inst_gnt   = grant_inst;
        data_gnt   = grant_data;
        inst_stall = !rst && inst_req && !grant_inst;
        data_stall = !rst && data_req && !grant_data;
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_sel   = 4'h0;
        sram_wdata = 32'h0;
        if (grant_inst) begin
            sram_ce   = 1'b1;
            sram_sel  = 4'hF;
            sram_addr = inst_addr[AW+1:2];
        end else if (grant_data) begin
            sram_ce    = 1'b1;
            sram_we    = data_we;
            sram_sel   = data_sel;
            sram_addr  = data_addr[AW+1:2];
            sram_wdata = data_wdata;
        end
    end

    // Return tag remembers who owns next cycle's sram_rdata; writes return nothing.
    always_comb begin
        state_next  = RET_NONE;
        starve_next = starve_cnt;
        if (grant_inst) begin
            state_next = RET_INST;
        end else if (grant_data && !data_we) begin
            state_next = RET_DATA;
        end
        if (!inst_req || grant_inst) begin
            starve_next = 4'd0;
        end else if (starve_cnt < LIMIT) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        inst_rvalid = (state == RET_INST);
        data_rvalid = (state == RET_DATA);
        rdata       = (inst_rvalid || data_rvalid) ? sram_rdata : 32'h0;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: AW, 17, SRAM word-address width; sram_addr = req addr[AW+1:2].
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive denied inst cycles before inst is forced priority (range 1..15).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 inst_req  in  1  instruction-fetch read request; held with inst_addr until inst_gnt.
REQ-006 inst_addr  in  32  byte address of fetch.
REQ-007 inst_gnt  out  1  fetch accepted this cycle.
REQ-008 inst_rvalid  out  1  inst read data valid on rdata.
REQ-009 data_req  in  1  load/store request; held with data_we, data_addr, data_sel, data_wdata until data_gnt.
REQ-010 data_we  in  1  1 = write, 0 = read.
REQ-011 data_addr  in  32  byte address.
REQ-012 data_sel  in  4  byte-lane enables.
REQ-013 data_wdata  in  32  write data.
REQ-014 data_gnt  out  1  data access accepted this cycle.
REQ-015 data_rvalid  out  1  data read data valid on rdata.
REQ-016 rdata  out  32  shared read-return bus, qualified by inst_rvalid/data_rvalid.
REQ-017 sram_ce, sram_we  out  1 each  SRAM chip and write enable.
REQ-018 sram_addr  out  AW  SRAM word address.
REQ-019 sram_sel  out  4  SRAM byte enables.
REQ-020 sram_wdata  out  32  SRAM write data.
REQ-021 sram_rdata  in  32  SRAM read data, valid one cycle after a read command.
REQ-022 inst_stall, data_stall  out  1 each  req high and gnt low this cycle, for pipeline stall logic.

Function
REQ-023 At most one grant per cycle; grant and SRAM command are combinational from the current request and registered state.
REQ-024 Default priority: data over inst.
REQ-025 Starvation counter (4 bit): +1 each cycle with inst_req & !inst_gnt, saturates at STARVE_LIMIT, clears on inst_gnt or inst_req low.
REQ-026 When the counter equals STARVE_LIMIT and inst_req is high, inst is granted even if data_req is high.
REQ-027 Inst grant drives sram_ce=1, sram_we=0, sram_sel=4'hF, sram_addr=inst_addr[AW+1:2], sram_wdata=0.
REQ-028 Data grant drives sram_ce=1, sram_we=data_we, sram_sel=data_sel, sram_addr=data_addr[AW+1:2], sram_wdata=data_wdata.
REQ-029 With no grant: sram_ce=0, sram_we=0, sram_sel=0, sram_addr=0, sram_wdata=0.
REQ-030 Return-tag FSM, states RET_NONE/RET_INST/RET_DATA: next state is RET_INST on inst grant, RET_DATA on data read grant, else RET_NONE (including data write).
REQ-031 inst_rvalid = (state==RET_INST); data_rvalid = (state==RET_DATA); rdata = sram_rdata when either is high, else 0.
REQ-032 Read latency: grant in cycle N -> rvalid and data in cycle N+1; back-to-back grants sustain one access per cycle.
REQ-033 Writes produce no rvalid; write completes at grant.
REQ-034 Request dropped without grant: no SRAM command, no state change except counter clear.

Reset
REQ-035 While rst high: all outputs 0, FSM RET_NONE, starvation counter 0.
REQ-036 Reset asserted mid-read: pending rvalid is discarded and not issued after reset release.
REQ-037 First grant is possible in the first clk edge cycle after rst deasserts.

Verification
REQ-038 Inst only, addr 0x0000_0010 -> inst_gnt same cycle, sram_addr=0x4, sram_sel=F; next cycle inst_rvalid=1, rdata=sram_rdata.
REQ-039 Data write addr 0x20, sel 4'b0011, wdata 0xDEADBEEF -> data_gnt, sram_we=1, sram_addr=0x8; next cycle no rvalid.
REQ-040 Both requesting continuously, STARVE_LIMIT=4 -> data granted 4 cycles, inst granted 5th cycle, counter 0, pattern repeats.
REQ-041 Data read then inst read back-to-back -> data_rvalid cycle N+1, inst_rvalid cycle N+2, rdata each matches SRAM model.
REQ-042 rst asserted cycle after a data read grant -> data_rvalid never asserts, all outputs 0 while rst high.
REQ-043 inst_req dropped after 3 denied cycles then reasserted -> counter restarts from 0, data keeps priority 4 more cycles.
